// File: rtl/fifo_byte_packer.sv
// Packs a byte stream little-endian into WIDTH-bit words with per-byte keep and a
// last flag, holding one finished word for an async FIFO write port.
module fifo_byte_packer #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk1,
    input  logic                   rstn,
    input  logic                   s_valid,
    input  logic [7:0]             s_data,
    input  logic                   s_last,
    output logic                   s_ready,
    input  logic                   fifo_full,
    output logic                   fifo_we,
    output logic [WIDTH+WIDTH/8:0] fifo_data,
    output logic                   busy,
    output logic [15:0]            word_count
);
    localparam int BYTES = WIDTH / 8;
    localparam int IW    = $clog2(BYTES);
    localparam int CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO      = CW'(TIMEOUT);
    localparam logic [IW-1:0] IDX_LAST = IW'(BYTES - 1);

    logic [WIDTH-1:0]       acc;
    logic [BYTES-1:0]       keep;
    logic [IW-1:0]          idx;
    logic [CW-1:0]          idle_cnt;
    logic [WIDTH+BYTES:0]   out_reg;
    logic                   out_pending;
    logic [15:0]            word_cnt;

    logic                   accept;
    logic                   word_done;
    logic                   flush_due;
    logic                   load;
    logic [WIDTH-1:0]       next_word;
    logic [BYTES-1:0]       next_keep;

    // Handshake: a byte transfers on a clk1 edge where s_valid & s_ready; the slot
    // counts as free when it is empty or being written this cycle, so s_ready never
    // depends on s_valid and the source may hold s_valid/s_data until accepted.
    assign fifo_we   = out_pending & ~fifo_full;
    assign s_ready   = ~out_pending | ~fifo_full;
    assign accept    = s_valid & s_ready;
    assign word_done = (idx == IDX_LAST) | s_last;
    assign flush_due = (TIMEOUT != 0) && (idx != '0) && (idle_cnt == TMO) && !accept && s_ready;
    assign load      = (accept & word_done) | flush_due;

    assign fifo_data  = out_reg;
    assign busy       = (idx != '0) | out_pending;
    assign word_count = word_cnt;

    // Lanes above idx are always zero, so OR-ing the new byte in is enough.
    always_comb begin
        next_word = acc | (WIDTH'(s_data) << (8 * idx));
        next_keep = keep | (BYTES'(1) << idx);
    end

    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            acc         <= '0;
            keep        <= '0;
            idx         <= '0;
            idle_cnt    <= '0;
            out_reg     <= '0;
            out_pending <= 1'b0;
            word_cnt    <= '0;
        end else begin
            if (accept) begin
                if (word_done) begin
                    out_reg <= {s_last, next_keep, next_word};
                    acc     <= '0;
                    keep    <= '0;
                    idx     <= '0;
                end else begin
                    acc  <= next_word;
                    keep <= next_keep;
                    idx  <= idx + 1'b1;
                end
            end else if (flush_due) begin
                out_reg <= {1'b0, keep, acc};
                acc     <= '0;
                keep    <= '0;
                idx     <= '0;
            end

            // A reload in the same cycle as a write keeps the slot occupied.
            if (load) begin
                out_pending <= 1'b1;
            end else if (fifo_we) begin
                out_pending <= 1'b0;
            end

            if (accept || (idx == '0) || flush_due) begin
                idle_cnt <= '0;
            end else if (idle_cnt != TMO) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (fifo_we && (word_cnt != 16'hFFFF)) begin
                word_cnt <= word_cnt + 16'd1;
            end
        end
    end
endmodule
